zap_copro_dispatch: RTL and testbench
=====================================

# zap_copro_dispatch

Coprocessor request dispatcher between the decode-stage coprocessor interface and up to 16 attached coprocessors. Latches a request (`dav`, word, reg, mode), selects the target from coprocessor number `word[11:8]`, and drives a one-hot request to that slot. It waits for that slot's acknowledge and returns a held `done` to decode. Absent coprocessors, privilege violations and unresponsive coprocessors complete as undefined-instruction.

## Interface
- `PHY_REGS`, 46, physical register count; `RW = $clog2(PHY_REGS)`.
- `CP_PRESENT`, 16'h8000, bit n set = coprocessor n attached (default CP15 only).
- `CP_PRIV`, 16'h8000, bit n set = coprocessor n is inaccessible from User mode.
- `TIMEOUT`, 255, maximum `WAIT` cycles before forced completion; must be ≥1.
- `i_clk`  in  1  clock, rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_copro_dav`  in  1  request valid level from decode, held until `o_copro_done` is observed.
- `i_copro_word`  in  32  full coprocessor instruction.
- `i_copro_reg`  in  RW  translated physical register.
- `i_copro_mode`  in  32  CPSR at request time.
- `o_copro_done`  out  1  completion, held until `i_copro_dav` falls.
- `o_copro_undef`  out  1  valid with `o_copro_done`: take undefined-instruction trap.
- `o_copro_timeout`  out  1  valid with `o_copro_done`: undef was caused by timeout.
- `o_cp_req`  out  16  one-hot request level to coprocessor n.
- `o_cp_word`  out  32  registered instruction to coprocessors.
- `o_cp_reg`  out  RW  registered register index.
- `o_cp_mode`  out  5  registered `i_copro_mode[4:0]`.
- `i_cp_ack`  in  16  per-coprocessor completion pulse.

## Operation
- States: `IDLE`, `WAIT`, `DONE`.
- `IDLE`: on `i_copro_dav=1`, latch word, reg and mode into `o_cp_*`; set n = `word[11:8]`.
  - If `CP_PRESENT[n]=0`, go to `DONE` with undef=1.
  - Else if `CP_PRIV[n]=1` and `mode[4:0]=5'b10000`, go to `DONE` with undef=1.
  - Otherwise set `o_cp_req` = 1<<n, clear the counter, and go to `WAIT`.
- `WAIT`: if `i_copro_dav=0` (pipeline flush), go to `IDLE`; clear `o_cp_req`; no done is issued. This check has highest priority.
  - Else if `i_cp_ack[n]=1`, go to `DONE` with undef=0 and clear `o_cp_req`. Ack bits for other slots are ignored.
  - Else, when the counter = `TIMEOUT-1`, go to `DONE` with undef=1 and timeout=1, and clear `o_cp_req`.
  - Otherwise increment the counter. Counter width is `$clog2(TIMEOUT+1)`; it never wraps.
- `DONE`: `o_copro_done=1`; `o_copro_undef` and `o_copro_timeout` hold their latched values. When `i_copro_dav=0`, go to `IDLE` and clear done, undef and timeout.
- `o_cp_word`, `o_cp_reg` and `o_cp_mode` hold their values from the latch point until the next latch.
- Any `i_cp_ack` in `IDLE` or `DONE` is ignored.
- `i_reset`: force state `IDLE`. All outputs and the counter go to 0 on the next edge, regardless of state.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- A request sampled at edge k gives `o_cp_req` high from cycle k+1.
- An ack sampled at edge m gives `o_copro_done` high from cycle m+1. Minimum request-to-done latency is 2 cycles.
- Undef on absent or privileged coprocessor: `o_copro_done` and `o_copro_undef` are high at cycle k+1; `o_cp_req` never asserts.
- Timeout: `o_cp_req` stays high for exactly `TIMEOUT` cycles, then `o_copro_done` asserts the following cycle.
- Done is held for as long as decode stalls; decode may sample it in any cycle.
- After `i_copro_dav` falls in `DONE`, the block returns to `IDLE`. A new request is accepted no earlier than the next cycle, giving at least one bubble.
- Ack and dav-fall in the same `WAIT` cycle: the abort wins; go to `IDLE` with no done.

## Test plan
- **Reset:** assert `i_reset` mid-`WAIT` with `o_cp_req`=16'h8000 → all outputs 0 next cycle; a later ack has no effect.
- **Normal completion:** MCR word 32'hEE010F10 (CP15), Supervisor mode (mode 5'b10011), dav=1 → `o_cp_req`=16'h8000 next cycle; ack[15] pulse 3 cycles later → done=1, undef=0 one cycle after the ack; done held until dav drops, then `IDLE`.
- **Absent coprocessor:** word 32'hEE010E10 (CP14) → done=1, undef=1 one cycle after the request; `o_cp_req` stays 0.
- **Privilege:** CP15 request in User mode (mode 5'b10000) → done=1, undef=1, no request issued. The same request in Supervisor mode → normal dispatch.
- **Timeout:** `TIMEOUT`=4, no ack → `o_cp_req` high for 4 cycles, then done=1, undef=1, timeout=1. An ack on slot 14 while waiting on CP15 is ignored.
- **Flush:** drop dav 2 cycles into `WAIT` → `IDLE` next cycle, no done. An ack[15] arriving afterwards causes no done.

Source files
------------

// File: rtl/zap_copro_dispatch.sv
// Coprocessor request dispatcher: latches a decode-stage coprocessor request,
// routes it as a one-hot request to the addressed coprocessor slot, waits for
// that slot's ack (or a timeout) and returns a held done/undef to decode.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_copro_dav           request valid level from decode (held until done)
//   i_copro_word/reg/mode instruction, physical register, CPSR at request
//   o_copro_done          completion, held until i_copro_dav falls
//   o_copro_undef         undefined-instruction trap (valid with done)
//   o_copro_timeout       undef was caused by an unresponsive coprocessor
//   o_cp_req              one-hot request level to coprocessor n
//   o_cp_word/reg/mode    registered request fields to coprocessors
//   i_cp_ack              per-coprocessor completion pulse
module zap_copro_dispatch #(
    parameter int          PHY_REGS   = 46,
    parameter logic [15:0] CP_PRESENT = 16'h8000,
    parameter logic [15:0] CP_PRIV    = 16'h8000,
    parameter int          TIMEOUT    = 255,
    localparam int         RW         = $clog2(PHY_REGS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_copro_dav,
    input  logic [31:0]   i_copro_word,
    input  logic [RW-1:0] i_copro_reg,
    input  logic [31:0]   i_copro_mode,
    output logic          o_copro_done,
    output logic          o_copro_undef,
    output logic          o_copro_timeout,
    output logic [15:0]   o_cp_req,
    output logic [31:0]   o_cp_word,
    output logic [RW-1:0] o_cp_reg,
    output logic [4:0]    o_cp_mode,
    input  logic [15:0]   i_cp_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [4:0] USR = 5'b10000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [15:0]   r_req, w_req;
    logic [31:0]   r_word, w_word;
    logic [RW-1:0] r_reg, w_reg;
    logic [4:0]    r_mode, w_mode;
    logic          r_done, w_done;
    logic          r_undef, w_undef;
    logic          r_tmo, w_tmo;
    logic [3:0]    w_n;
    logic [3:0]    w_slot;
    logic          w_unused_mode;

    // Only the mode field of the CPSR matters here.
    assign w_unused_mode = ^i_copro_mode[31:5];

    // Slot of the request in flight; the latched word is stable until relatch.
    assign w_slot = r_word[11:8];
    assign w_n    = i_copro_word[11:8];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_word  <= '0;
            r_reg   <= '0;
            r_mode  <= '0;
            r_done  <= 1'b0;
            r_undef <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_req   <= w_req;
            r_word  <= w_word;
            r_reg   <= w_reg;
            r_mode  <= w_mode;
            r_done  <= w_done;
            r_undef <= w_undef;
            r_tmo   <= w_tmo;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_req   = r_req;
        w_word  = r_word;
        w_reg   = r_reg;
        w_mode  = r_mode;
        w_done  = r_done;
        w_undef = r_undef;
        w_tmo   = r_tmo;
        unique case (r_state)
            IDLE: begin
                if (i_copro_dav) begin
                    w_word = i_copro_word;
                    w_reg  = i_copro_reg;
                    w_mode = i_copro_mode[4:0];
                    w_tmo  = 1'b0;
                    if (!CP_PRESENT[w_n] ||
                        (CP_PRIV[w_n] && i_copro_mode[4:0] == USR)) begin
                        w_state = DONE;
                        w_done  = 1'b1;
                        w_undef = 1'b1;
                    end else begin
                        w_state = WAIT;
                        w_req   = 16'(1) << w_n;
                        w_cnt   = '0;
                    end
                end
            end
            WAIT: begin
                // A flush outranks an ack arriving in the same cycle.
                if (!i_copro_dav) begin
                    w_state = IDLE;
                    w_req   = '0;
                end else if (i_cp_ack[w_slot]) begin
                    w_state = DONE;
                    w_req   = '0;
                    w_done  = 1'b1;
                    w_undef = 1'b0;
                end else if (r_cnt == LAST) begin
                    w_state = DONE;
                    w_req   = '0;
                    w_done  = 1'b1;
                    w_undef = 1'b1;
                    w_tmo   = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            DONE: begin
                if (!i_copro_dav) begin
                    w_state = IDLE;
                    w_done  = 1'b0;
                    w_undef = 1'b0;
                    w_tmo   = 1'b0;
                end
            end
            default: begin
                w_state = IDLE;
                w_req   = '0;
                w_done  = 1'b0;
                w_undef = 1'b0;
                w_tmo   = 1'b0;
            end
        endcase
    end

    assign o_copro_done    = r_done;
    assign o_copro_undef   = r_undef;
    assign o_copro_timeout = r_tmo;
    assign o_cp_req        = r_req;
    assign o_cp_word       = r_word;
    assign o_cp_reg        = r_reg;
    assign o_cp_mode       = r_mode;

endmodule

// File: tb/tb_zap_copro_dispatch.sv
// Testbench for zap_copro_dispatch: directed requests with a completion
// scoreboard (expected undef/timeout queued at issue, checked on done rise).
module tb_zap_copro_dispatch;

    localparam int RW = 6;

    logic          clk;
    logic          rst;
    logic          dav;
    logic [31:0]   word;
    logic [RW-1:0] rg;
    logic [31:0]   mode;
    logic          done;
    logic          undef;
    logic          tmo;
    logic [15:0]   req;
    logic [31:0]   cp_word;
    logic [RW-1:0] cp_reg;
    logic [4:0]    cp_mode;
    logic [15:0]   ack;

    int n_cmp;
    int n_bad;

    logic [1:0] exp_q[$];

    zap_copro_dispatch #(
        .TIMEOUT(4)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_copro_dav    (dav),
        .i_copro_word   (word),
        .i_copro_reg    (rg),
        .i_copro_mode   (mode),
        .o_copro_done   (done),
        .o_copro_undef  (undef),
        .o_copro_timeout(tmo),
        .o_cp_req       (req),
        .o_cp_word      (cp_word),
        .o_cp_reg       (cp_reg),
        .o_cp_mode      (cp_mode),
        .i_cp_ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req_v);
        end
    endtask

    task automatic issue(input logic [31:0] w, input logic [4:0] m,
                         input logic [RW-1:0] r, input logic [1:0] e);
        word = w;
        mode = {27'h0, m};
        rg   = r;
        dav  = 1'b1;
        exp_q.push_back(e);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst  = 1'b1;
        dav  = 1'b0;
        word = '0;
        rg   = '0;
        mode = '0;
        ack  = '0;

        fork
            begin : monitor
                logic prev;
                logic [1:0] e;
                prev = 1'b0;
                forever begin
                    @(negedge clk);
                    if (done && !prev) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL sb_unexpected: done with undef=%b tmo=%b, expected no done",
                                     undef, tmo);
                        end else begin
                            e = exp_q.pop_front();
                            chk("sb_undef_tmo", {30'h0, undef, tmo}, {30'h0, e});
                        end
                    end
                    prev = done;
                end
            end
        join_none

        tick();
        tick();
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_req", {16'h0, req}, 32'h0);
        chk("rst_word", cp_word, 32'h0);
        rst = 1'b0;
        tick();

        // Normal MCR to CP15 in Supervisor mode, ack three cycles later.
        issue(32'hEE010F10, 5'b10011, 6'd37, 2'b00);
        tick();
        chk("norm_req", {16'h0, req}, 32'h8000);
        chk("norm_word", cp_word, 32'hEE010F10);
        chk("norm_reg", {26'h0, cp_reg}, 32'd37);
        chk("norm_mode", {27'h0, cp_mode}, 32'h13);
        tick();
        tick();
        ack = 16'h8000;
        tick();
        ack = '0;
        chk("norm_done", {30'h0, done, undef}, 32'h2);
        chk("norm_req_off", {16'h0, req}, 32'h0);
        tick();
        tick();
        chk("norm_hold", {31'h0, done}, 32'h1);
        dav = 1'b0;
        tick();
        chk("norm_release", {31'h0, done}, 32'h0);

        // Absent coprocessor 14.
        issue(32'hEE010E10, 5'b10011, 6'd3, 2'b10);
        tick();
        chk("absent_done", {30'h0, done, undef}, 32'h3);
        chk("absent_req", {16'h0, req}, 32'h0);
        dav = 1'b0;
        tick();

        // CP15 from User mode is privileged.
        issue(32'hEE010F10, 5'b10000, 6'd1, 2'b10);
        tick();
        chk("priv_done", {30'h0, done, undef}, 32'h3);
        chk("priv_req", {16'h0, req}, 32'h0);
        dav = 1'b0;
        tick();

        // Same request from Supervisor: minimum 2-cycle latency.
        issue(32'hEE010F10, 5'b10011, 6'd1, 2'b00);
        tick();
        chk("svc_req", {16'h0, req}, 32'h8000);
        ack = 16'h8000;
        tick();
        ack = '0;
        chk("svc_done", {30'h0, done, undef}, 32'h2);
        dav = 1'b0;
        tick();

        // Timeout with a stray ack on slot 14.
        issue(32'hEE010F10, 5'b10011, 6'd2, 2'b11);
        ack = 16'h4000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tmo_req_high", {16'h0, req}, 32'h8000);
            chk("tmo_no_done", {31'h0, done}, 32'h0);
        end
        tick();
        ack = '0;
        chk("tmo_done", {29'h0, done, undef, tmo}, 32'h7);
        chk("tmo_req_off", {16'h0, req}, 32'h0);
        dav = 1'b0;
        tick();
        chk("tmo_clear", {29'h0, done, undef, tmo}, 32'h0);

        // Flush two cycles into WAIT, then a late ack.
        word = 32'hEE010F10;
        mode = 32'h13;
        dav  = 1'b1;
        tick();
        tick();
        dav = 1'b0;
        tick();
        chk("flush_req", {16'h0, req}, 32'h0);
        chk("flush_done", {31'h0, done}, 32'h0);
        ack = 16'h8000;
        tick();
        ack = '0;
        tick();
        chk("flush_late_ack", {31'h0, done}, 32'h0);

        // Reset in the middle of WAIT.
        issue(32'hEE010F10, 5'b10011, 6'd9, 2'b00);
        void'(exp_q.pop_back());
        tick();
        chk("rstw_req", {16'h0, req}, 32'h8000);
        tick();
        rst = 1'b1;
        dav = 1'b0;
        tick();
        chk("rstw_req_off", {16'h0, req}, 32'h0);
        chk("rstw_word", cp_word, 32'h0);
        chk("rstw_flags", {29'h0, done, undef, tmo}, 32'h0);
        rst = 1'b0;
        ack = 16'h8000;
        tick();
        ack = '0;
        tick();
        chk("rstw_late_ack", {15'h0, done, req}, 32'h0);

        tick();
        chk("sb_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
